// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the data-memory access unit:
//   - access-size encodings driven by the MEM stage (mode)
//   - FSM state encoding used by mem_access_unit
//   - lane width constants and a small mode-decoding helper
// ---------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;  // 2'b11 is also treated as word

    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } state_t;

    // Both 2'b10 and 2'b11 select a full-word access.
    function automatic logic is_word(input logic [1:0] m);
        return m[1];
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// ---------------------------------------------------------------------------
// mau_lane_align
// Combinational lane handling for the memory access unit.
//   mode      in  2   access size (byte / half / word)
//   byte_off  in  2   byte offset within the word (addr[1:0])
//   sign_ext  in  1   loads: 1 sign-extend, 0 zero-extend
//   ld_word   in  32  word returned by the RAM (load path)
//   rmw_word  in  32  word previously read for a sub-word store
//   st_data   in  32  store data, value in the LSBs for byte/half
//   ld_data   out 32  extracted and extended load value
//   st_word   out 32  word to write back to the RAM
// Lanes are little-endian: byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
// ---------------------------------------------------------------------------
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  byte_off,
    input  logic        sign_ext,
    input  logic [31:0] ld_word,
    input  logic [31:0] rmw_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [BYTE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;

    // Load extract: half accesses only look at addr[1], so the low offset
    // bit is ignored for halves.
    always_comb begin
        ld_byte = ld_word[{byte_off, 3'b000} +: BYTE_W];
        ld_half = ld_word[{byte_off[1], 4'b0000} +: HALF_W];
        case (mode)
            MODE_BYTE: ld_data = {{(DATA_W-BYTE_W){sign_ext & ld_byte[BYTE_W-1]}}, ld_byte};
            MODE_HALF: ld_data = {{(DATA_W-HALF_W){sign_ext & ld_half[HALF_W-1]}}, ld_half};
            default:   ld_data = ld_word;
        endcase
    end

    // Store merge: only the addressed lane of the previously read word is
    // replaced; word stores bypass the read word entirely.
    always_comb begin
        st_word = rmw_word;
        case (mode)
            MODE_BYTE: st_word[{byte_off, 3'b000} +: BYTE_W]    = st_data[BYTE_W-1:0];
            MODE_HALF: st_word[{byte_off[1], 4'b0000} +: HALF_W] = st_data[HALF_W-1:0];
            default:   st_word = st_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store responder between the MEM stage and a word-only synchronous RAM
// (req/ack handshake, no byte enables). Sub-word stores are performed as
// read-modify-write; sub-word loads are lane-extracted and extended.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   mode, mem_write,
//   sign_ext, addr, wdata  request fields, latched on accept
//   rsp_valid, rdata       one-cycle completion pulse, load result
//   misalign               with rsp_valid: request was misaligned
//   mem_req/mem_we/
//   mem_addr/mem_wdata     RAM request side, mem_req held until mem_ack
//   mem_ack/mem_rdata      RAM completion, read data valid with ack
//
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses without touching the RAM. Otherwise low address bits are ignored.
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        mode,
    input  logic              mem_write,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic               we_q;
    logic               sext_q;
    logic [1:0]         off_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rd_word_q;    // merge register for read-modify-write
    logic [31:0]        rdata_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               misalign_q;

    logic               accept;
    logic               misalign_in;
    logic [31:0]        ld_data;
    logic [31:0]        st_word;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign accept = (state_q == IDLE) && req_valid;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_in = ((mode == MODE_HALF) && addr[0]) ||
                         (is_word(mode) && (addr[1:0] != 2'b00));
`else
    assign misalign_in = 1'b0;
`endif

    mau_lane_align u_lane_align (
        .mode     (mode_q),
        .byte_off (off_q),
        .sign_ext (sext_q),
        .ld_word  (mem_rdata),
        .rmw_word (rd_word_q),
        .st_data  (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misalign_in)
                        state_d = RSP;
                    else if (mem_write && is_word(mode))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            // RD is only followed by WR for sub-word stores.
            RD:      if (mem_ack) state_d = we_q ? WR : RSP;
            WR:      if (mem_ack) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_BYTE;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            rd_word_q  <= '0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                mode_q     <= mode;
                we_q       <= mem_write;
                sext_q     <= sign_ext;
                off_q      <= addr[1:0];
                wdata_q    <= wdata;
                mem_addr_q <= addr[ADDR_W+1:2];
                misalign_q <= misalign_in;
                if (misalign_in)
                    rdata_q <= '0;
            end
            if ((state_q == RD) && mem_ack) begin
                rd_word_q <= mem_rdata;
                if (!we_q)
                    rdata_q <= ld_data;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign misalign  = (state_q == RSP) && misalign_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == RD) || (state_q == WR);
    assign mem_we    = (state_q == WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = st_word;

endmodule
